regwrite_queue: RTL and testbench

REGWRITE_QUEUE -- requirements
Module: regwrite_queue

---
 rtl/regwq_pkg.sv | 19 +
 rtl/regwq_fwd.sv | 32 +++
 rtl/regwrite_queue.sv | 129 ++++++++++++
 tb/tb_regwrite_queue.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/regwq_pkg.sv
// Shared constants and the default-width entry layout for the register write-back queue.
// Instances with other widths build the same {addr, data} layout from their own parameters.
package regwq_pkg;

    localparam int REGWQ_DEFAULT_N     = 16;
    localparam int REGWQ_DEFAULT_R     = 4;
    localparam int REGWQ_DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [REGWQ_DEFAULT_R-1:0] addr;
        logic [REGWQ_DEFAULT_N-1:0] data;
    } regwq_entry_t;

    // Pointer width for a power-of-two depth, never narrower than one bit.
    function automatic int regwq_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regwq_fwd.sv
// Youngest-match search over the queue contents ordered oldest (index 0) to youngest.
// Register 0 never forwards.
module regwq_fwd
    import regwq_pkg::*;
#(
    parameter int n     = REGWQ_DEFAULT_N,
    parameter int r     = REGWQ_DEFAULT_R,
    parameter int DEPTH = REGWQ_DEFAULT_DEPTH
) (
    input  logic [r-1:0]            ra_i,
    input  logic [DEPTH-1:0][r-1:0] addr_i,
    input  logic [DEPTH-1:0][n-1:0] data_i,
    input  logic [DEPTH-1:0]        vld_i,
    output logic                    hit_o,
    output logic [n-1:0]            data_o
);

    // Later (younger) matches overwrite earlier ones.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        if (ra_i != '0) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (vld_i[k] && (addr_i[k] == ra_i)) begin
                    hit_o  = 1'b1;
                    data_o = data_i[k];
                end
            end
        end
    end

endmodule

// File: rtl/regwrite_queue.sv
// Write-back queue between ALU/load results and a single register-file write port,
// with pending-write forwarding for two read ports.
module regwrite_queue
    import regwq_pkg::*;
#(
    parameter int n     = REGWQ_DEFAULT_N,
    parameter int r     = REGWQ_DEFAULT_R,
    parameter int DEPTH = REGWQ_DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [r-1:0]               alu_addr,
    input  logic [n-1:0]               alu_data,
    input  logic                       mem_valid,
    input  logic [r-1:0]               mem_addr,
    input  logic [n-1:0]               mem_data,
    output logic                       enq_ready,
    output logic                       we3,
    output logic [r-1:0]               wa3,
    output logic [n-1:0]               wd3,
    input  logic [r-1:0]               ra1,
    input  logic [r-1:0]               ra2,
    output logic                       fwd1_hit,
    output logic [n-1:0]               fwd1_data,
    output logic                       fwd2_hit,
    output logic [n-1:0]               fwd2_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int PW = regwq_ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [r-1:0] addr;
        logic [n-1:0] data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] wr_ptr_alu;
    logic [CW-1:0] count_q, count_d;
    logic          push_mem, push_alu, pop;
    entry_t        head;

    // Two free slots are demanded so a dual push can never overflow.
    assign enq_ready  = (count_q <= CW'(DEPTH - 2));
    assign push_mem   = mem_valid && enq_ready && (mem_addr != '0);
    assign push_alu   = alu_valid && enq_ready && (alu_addr != '0);
    assign pop        = (count_q != '0);
    assign wr_ptr_alu = wr_ptr_q + PW'(push_mem);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_mem) + PW'(push_alu);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push_mem) + CW'(push_alu) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Load result takes the older slot when both producers push together.
    always_ff @(posedge clk) begin
        if (push_mem) mem_q[wr_ptr_q]   <= '{addr: mem_addr, data: mem_data};
        if (push_alu) mem_q[wr_ptr_alu] <= '{addr: alu_addr, data: alu_data};
    end

    assign head  = mem_q[rd_ptr_q];
    assign we3   = pop;
    assign wa3   = pop ? head.addr : '0;
    assign wd3   = pop ? head.data : '0;
    assign count = count_q;
    assign empty = (count_q == '0);

    logic [DEPTH-1:0][r-1:0] ord_addr;
    logic [DEPTH-1:0][n-1:0] ord_data;
    logic [DEPTH-1:0]        ord_vld;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ord
            logic [PW-1:0] idx;
            assign idx          = rd_ptr_q + PW'(gi);
            assign ord_addr[gi] = mem_q[idx].addr;
            assign ord_data[gi] = mem_q[idx].data;
            assign ord_vld[gi]  = (CW'(gi) < count_q);
        end
    endgenerate

    logic [1:0][r-1:0] ra_all;
    logic [1:0]        hit_all;
    logic [1:0][n-1:0] fdata_all;

    assign ra_all = {ra2, ra1};

    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            regwq_fwd #(
                .n     (n),
                .r     (r),
                .DEPTH (DEPTH)
            ) u_fwd (
                .ra_i   (ra_all[gi]),
                .addr_i (ord_addr),
                .data_i (ord_data),
                .vld_i  (ord_vld),
                .hit_o  (hit_all[gi]),
                .data_o (fdata_all[gi])
            );
        end
    endgenerate

    assign fwd1_hit  = hit_all[0];
    assign fwd1_data = fdata_all[0];
    assign fwd2_hit  = hit_all[1];
    assign fwd2_data = fdata_all[1];

endmodule

// File: tb/tb_regwrite_queue.sv
// Directed bench for regwrite_queue: stimulus pushes expected writes into a scoreboard,
// an independent monitor pops and compares each presented register-file write.
module tb_regwrite_queue;

    localparam int N     = 16;
    localparam int R     = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, mem_valid;
    logic [R-1:0]  alu_addr, mem_addr;
    logic [N-1:0]  alu_data, mem_data;
    logic          enq_ready, we3;
    logic [R-1:0]  wa3;
    logic [N-1:0]  wd3;
    logic [R-1:0]  ra1, ra2;
    logic          fwd1_hit, fwd2_hit;
    logic [N-1:0]  fwd1_data, fwd2_data;
    logic [CW-1:0] count;
    logic          empty;

    regwrite_queue #(.n(N), .r(R), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .enq_ready (enq_ready),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3),
        .ra1       (ra1),
        .ra2       (ra2),
        .fwd1_hit  (fwd1_hit),
        .fwd1_data (fwd1_data),
        .fwd2_hit  (fwd2_hit),
        .fwd2_data (fwd2_data),
        .count     (count),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int mcount = 0;
    logic [R+N-1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Each write presented at a falling edge commits at the next rising edge.
    always @(negedge clk) begin
        if (!rst && we3) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(wa3), 32'hFFFF_FFFF);
            end else begin
                logic [R+N-1:0] e;
                e = exp_q.pop_front();
                check("wa3", 32'(wa3), 32'(e[R+N-1:N]));
                check("wd3", 32'(wd3), 32'(e[N-1:0]));
                $display("write reg %0d <= 0x%04h (expected reg %0d <= 0x%04h)",
                         wa3, wd3, e[R+N-1:N], e[N-1:0]);
            end
        end
    end

    // Drive one cycle of requests from a falling edge to the next one.
    task automatic step(input logic mv, input logic [R-1:0] ma, input logic [N-1:0] md,
                        input logic av, input logic [R-1:0] aa, input logic [N-1:0] ad);
        int   pushes;
        logic rdy;
        rdy = (mcount <= DEPTH - 2);
        check("enq_ready", 32'(enq_ready), 32'(rdy));
        mem_valid = mv; mem_addr = ma; mem_data = md;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        pushes = 0;
        if ((mv || av) && !rdy) $display("note: producer protocol violation, request dropped");
        if (mv && rdy && ma != 0) begin exp_q.push_back({ma, md}); pushes++; end
        if (av && rdy && aa != 0) begin exp_q.push_back({aa, ad}); pushes++; end
        @(negedge clk);
        mcount = mcount + pushes - ((mcount != 0) ? 1 : 0);
        mem_valid = 1'b0; alu_valid = 1'b0;
        check("count", 32'(count), 32'(mcount));
        check("empty", 32'(empty), 32'(mcount == 0));
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        ra1 = 4'd5; ra2 = 4'd3;
        @(negedge clk); @(negedge clk);
        check("rst_we3", 32'(we3), 32'd0);
        check("rst_wa3", 32'(wa3), 32'd0);
        check("rst_wd3", 32'(wd3), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_enq_ready", 32'(enq_ready), 32'd1);
        check("rst_fwd1_hit", 32'(fwd1_hit), 32'd0);
        check("rst_fwd2_hit", 32'(fwd2_hit), 32'd0);
        rst = 1'b0;
        ra1 = '0; ra2 = '0;

        // Single ALU write, one-cycle latency.
        step(1'b0, '0, '0, 1'b1, 4'd3, 16'h00AA);
        check("lat_we3", 32'(we3), 32'd1);
        idle();
        check("drained_empty", 32'(empty), 32'd1);
        check("drained_we3", 32'(we3), 32'd0);

        // Same-cycle load and ALU to the same register; youngest forwards.
        step(1'b1, 4'd5, 16'h1111, 1'b1, 4'd5, 16'h2222);
        ra1 = 4'd5; ra2 = 4'd6;
        #1;
        check("fwd1_hit_dual", 32'(fwd1_hit), 32'd1);
        check("fwd1_data_dual", 32'(fwd1_data), 32'h2222);
        check("fwd2_hit_nomatch", 32'(fwd2_hit), 32'd0);
        check("fwd2_data_nomatch", 32'(fwd2_data), 32'd0);
        idle();
        ra2 = 4'd5;
        #1;
        check("fwd2_hit_tail", 32'(fwd2_hit), 32'd1);
        check("fwd2_data_tail", 32'(fwd2_data), 32'h2222);
        idle();
        #1;
        check("fwd1_hit_gone", 32'(fwd1_hit), 32'd0);

        // Register 0 is discarded and never forwards.
        step(1'b0, '0, '0, 1'b1, 4'd0, 16'hFFFF);
        check("r0_we3", 32'(we3), 32'd0);
        ra2 = 4'd0;
        #1;
        check("r0_fwd2_hit", 32'(fwd2_hit), 32'd0);
        check("r0_fwd2_data", 32'(fwd2_data), 32'd0);

        // Fill with dual pushes, then steady one push and one pop per cycle.
        step(1'b1, 4'd6, 16'h0606, 1'b1, 4'd7, 16'h0707);
        step(1'b1, 4'd8, 16'h0808, 1'b1, 4'd9, 16'h0909);
        check("full_count", 32'(count), 32'd3);
        check("full_enq_ready", 32'(enq_ready), 32'd0);
        idle();
        for (int i = 0; i < 20; i++) begin
            step(1'b0, '0, '0, 1'b1, 4'(1 + (i % 15)), 16'(16'h1000 + i));
            check("steady_count", 32'(count), 32'd2);
        end
        for (int i = 0; i < 10 && mcount != 0; i++) idle();
        check("drain_sb_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset with three pending entries.
        step(1'b1, 4'd10, 16'hA0A0, 1'b1, 4'd11, 16'hB0B0);
        step(1'b1, 4'd12, 16'hC0C0, 1'b1, 4'd13, 16'hD0D0);
        #2 rst = 1'b1;
        #1;
        check("midrst_we3", 32'(we3), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);
        check("midrst_enq_ready", 32'(enq_ready), 32'd1);
        exp_q.delete();
        mcount = 0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        idle();
        idle();
        step(1'b0, '0, '0, 1'b1, 4'd12, 16'hBEEF);
        idle();
        check("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
